// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the memory-controller side of mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              we0, we1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, we0, we1, wdata0, wdata1, mem_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy, mem_address, mem_write_enable, mem_in
  );

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, we0, we1, wdata0, wdata1, mem_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy, mem_address, mem_write_enable, mem_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-RAM memory controller between two engines,
// with an optional bounded lock so one port can issue a short back-to-back burst.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state_reg, state_next;
  logic               last_reg, last_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [1:0]         rvalid_reg;

  logic [1:0]         req, lock, we, gnt;
  logic [ADDR_W-1:0]  addr  [2];
  logic [DATA_W-1:0]  wdata [2];
  logic               owner;
  logic               busy;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  assign req      = {bus.req1, bus.req0};
  assign lock     = {bus.lock1, bus.lock0};
  assign we       = {bus.we1, bus.we0};
  assign addr[0]  = bus.addr0;
  assign addr[1]  = bus.addr1;
  assign wdata[0] = bus.wdata0;
  assign wdata[1] = bus.wdata1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      burst_cnt_reg <= '0;
      rvalid_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
      rvalid_reg    <= gnt & ~we;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    gnt            = '0;
    busy           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    owner          = (state_reg == OWN1);

    case (state_reg)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (req[0] && req[1]) state_next = last_reg ? OWN0 : OWN1;
        else if (req[0])      state_next = OWN0;
        else if (req[1])      state_next = OWN1;
      end
      default: begin
        busy      = 1'b1;
        mem_addr  = addr[owner];
        mem_wdata = wdata[owner];
        if (req[owner]) begin
          gnt[owner] = 1'b1;
          mem_we     = we[owner];
          if (lock[owner] && (burst_cnt_reg < BURST_LAST)) begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end else begin
            last_next      = owner;
            burst_cnt_next = '0;
            if (req[~owner]) state_next = owner ? OWN0 : OWN1;
          end
        end else begin
          // Owner withdrew: hand over or fall back to idle without an access.
          last_next      = owner;
          burst_cnt_next = '0;
          state_next     = req[~owner] ? (owner ? OWN0 : OWN1) : IDLE;
        end
      end
    endcase
  end

  assign bus.gnt0             = gnt[0];
  assign bus.gnt1             = gnt[1];
  assign bus.rvalid0          = rvalid_reg[0];
  assign bus.rvalid1          = rvalid_reg[1];
  assign bus.rdata            = bus.mem_out;
  assign bus.busy             = busy;
  assign bus.mem_address      = mem_addr;
  assign bus.mem_write_enable = mem_we;
  assign bus.mem_in           = mem_wdata;
endmodule
